// File: rtl/shift_ctrl_pkg.sv
// Shared types and constants for the shift-register command sequencer.
// Optional feature macro used by the controller: SHIFT_CTRL_ROTATE_EN.
package shift_ctrl_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 3;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/shift_ctrl_counter.sv
// Loadable down-counter holding the remaining shift count; saturates at zero.
// Latency 1 cycle from load/dec to count; no backpressure.
module shift_ctrl_counter #(
  parameter int W = 3
) (
  input  logic         clockPulse,
  input  logic         Reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clockPulse or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);
  // Terminal count: the shift being performed now is the last one.
  assign tc_o   = (cnt_q == W'(1));

endmodule

// File: rtl/shift_register_controller.sv
// Command sequencer for the 4-bit priority shift register: load, then N shifts, then done pulse.
// Command accepted only in IDLE (cmdReady); N+2 cycles per command. Macro: SHIFT_CTRL_ROTATE_EN.
module shift_register_controller
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clockPulse,
  input  logic             Reset,
  input  logic             cmdValid,
  output logic             cmdReady,
  input  logic             cmdDir,
  input  logic [WIDTH-1:0] cmdData,
  input  logic [CNT_W-1:0] cmdCount,
  input  logic             cmdFill,
  input  logic             ShiftOutput,
  output logic             ParallelLoad,
  output logic             ShiftLeft,
  output logic             ShiftRight,
  output logic             ShiftInput,
  output logic [WIDTH-1:0] Data,
  output logic             serialOut,
  output logic             serialValid,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  state_e           state_q;
  logic             ready_q, pl_q, sl_q, sr_q, sv_q, busy_q, done_q;
  logic             dir_q;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_rem;
  logic             cnt_zero, cnt_tc, accept;
`ifndef SHIFT_CTRL_ROTATE_EN
  logic             fill_q;
`endif

  assign accept = (state_q == IDLE) && cmdValid && ready_q;
  assign cnt_d  = (cmdCount > CNT_MAX) ? CNT_MAX : cmdCount;

  shift_ctrl_counter #(.W(CNT_W)) u_cnt (
    .clockPulse (clockPulse),
    .Reset      (Reset),
    .load_i     (accept),
    .load_val_i (cnt_d),
    .dec_i      (state_q == SHIFT),
    .cnt_o      (cnt_rem),
    .zero_o     (cnt_zero),
    .tc_o       (cnt_tc)
  );

  always_ff @(posedge clockPulse or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      pl_q    <= 1'b0;
      sl_q    <= 1'b0;
      sr_q    <= 1'b0;
      sv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dir_q   <= DIR_LEFT;
      data_q  <= '0;
`ifndef SHIFT_CTRL_ROTATE_EN
      fill_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= LOAD;
            ready_q <= 1'b0;
            pl_q    <= 1'b1;
            busy_q  <= 1'b1;
            dir_q   <= cmdDir;
            data_q  <= cmdData;
`ifndef SHIFT_CTRL_ROTATE_EN
            fill_q  <= cmdFill;
`endif
          end else begin
            ready_q <= 1'b1;
          end
        end
        LOAD: begin
          pl_q <= 1'b0;
          if (!cnt_zero) begin
            state_q <= SHIFT;
            // Strobes decoded from one direction bit, so never both high.
            sl_q    <= (dir_q == DIR_LEFT);
            sr_q    <= (dir_q == DIR_RIGHT);
            sv_q    <= 1'b1;
          end else begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        SHIFT: begin
          if (cnt_tc) begin
            state_q <= DONE;
            sl_q    <= 1'b0;
            sr_q    <= 1'b0;
            sv_q    <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmdReady     = ready_q;
  assign ParallelLoad = pl_q;
  assign ShiftLeft    = sl_q;
  assign ShiftRight   = sr_q;
  assign serialValid  = sv_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign Data         = data_q;
  assign serialOut    = sv_q & ShiftOutput;
`ifdef SHIFT_CTRL_ROTATE_EN
  assign ShiftInput   = sv_q & ShiftOutput;
`else
  assign ShiftInput   = sv_q & fill_q;
`endif

endmodule

// File: tb/tb_shift_register_controller.sv
// Directed bench: controller driving a behavioural 4-bit priority shift register.
module tb_shift_register_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmdValid, cmdReady, cmdDir, cmdFill;
  logic [3:0] cmdData;
  logic [2:0] cmdCount;
  logic       ShiftOutput, ParallelLoad, ShiftLeft, ShiftRight, ShiftInput;
  logic [3:0] Data;
  logic       serialOut, serialValid, busy, done;
  logic [3:0] sreg;

  int n_cmp = 0;
  int n_err = 0;

  int         r_load, r_left, r_right, r_both, r_nser, r_donec, r_rdy;
  logic [7:0] r_ser;
  logic [3:0] r_dload;

  always #5 clk = ~clk;

  shift_register_controller #(.WIDTH(4), .CNT_W(3)) dut (
    .clockPulse   (clk),
    .Reset        (rst),
    .cmdValid     (cmdValid),
    .cmdReady     (cmdReady),
    .cmdDir       (cmdDir),
    .cmdData      (cmdData),
    .cmdCount     (cmdCount),
    .cmdFill      (cmdFill),
    .ShiftOutput  (ShiftOutput),
    .ParallelLoad (ParallelLoad),
    .ShiftLeft    (ShiftLeft),
    .ShiftRight   (ShiftRight),
    .ShiftInput   (ShiftInput),
    .Data         (Data),
    .serialOut    (serialOut),
    .serialValid  (serialValid),
    .busy         (busy),
    .done         (done)
  );

  // Priority register: Reset > ParallelLoad > ShiftLeft > ShiftRight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               sreg <= 4'b0000;
    else if (ParallelLoad) sreg <= Data;
    else if (ShiftLeft)    sreg <= {sreg[2:0], ShiftInput};
    else if (ShiftRight)   sreg <= {ShiftInput, sreg[3:1]};
  end
  assign ShiftOutput = ShiftLeft ? sreg[3] : (ShiftRight ? sreg[0] : 1'b0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_cmd(input logic dir, input logic [3:0] dat, input logic [2:0] cnt,
                         input logic fill, input bit interfere);
    int w;
    r_load = 0; r_left = 0; r_right = 0; r_both = 0; r_nser = 0;
    r_donec = 0; r_rdy = 0; r_ser = '0; r_dload = 'x;
    w = 0;
    while (!cmdReady && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("ready_wait", cmdReady, 1);
    cmdValid = 1'b1; cmdDir = dir; cmdData = dat; cmdCount = cnt; cmdFill = fill;
    @(posedge clk);
    #1 cmdValid = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (ParallelLoad) begin r_load++; r_dload = Data; end
      if (ShiftLeft) r_left++;
      if (ShiftRight) r_right++;
      if (ShiftLeft && ShiftRight) r_both++;
      if (serialValid) begin r_ser = {r_ser[6:0], serialOut}; r_nser++; end
      if (cmdReady) r_rdy++;
      if (done) begin r_donec = c; break; end
      if (interfere && c == 2) begin
        cmdValid = 1'b1; cmdDir = ~dir; cmdData = 4'hF; cmdCount = 3'd1; cmdFill = 1'b1;
      end
    end
    cmdValid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int dseen;
    rst = 1'b1; cmdValid = 1'b0; cmdDir = 1'b0; cmdData = '0; cmdCount = '0; cmdFill = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", {cmdReady, ParallelLoad, ShiftLeft, ShiftRight, ShiftInput,
                        serialOut, serialValid, busy, done}, 9'h0);
    chk("rst_data", Data, 4'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_before_edge", cmdReady, 0);
    @(negedge clk);
    chk("ready_after_rst", cmdReady, 1);

    // Left, 1001, one shift, fill 1.
    run_cmd(1'b0, 4'b1001, 3'd1, 1'b1, 1'b0);
    chk("t1_load", r_load, 1);
    chk("t1_data", r_dload, 4'b1001);
    chk("t1_left", r_left, 1);
    chk("t1_right", r_right, 0);
    chk("t1_ser", {r_nser[3:0], r_ser}, {4'd1, 8'h01});
    chk("t1_reg", sreg, 4'b0011);
    chk("t1_latency", r_donec, 3);
    chk("t1_rdy_busy", r_rdy, 0);
    @(negedge clk);
    chk("t1_done_pulse", {done, busy}, 2'b00);

    // Right, 1001, four shifts, fill 0.
    run_cmd(1'b1, 4'b1001, 3'd4, 1'b0, 1'b0);
    chk("t2_right", r_right, 4);
    chk("t2_left", r_left, 0);
    chk("t2_ser", {r_nser[3:0], r_ser}, {4'd4, 8'b0000_1001});
`ifdef SHIFT_CTRL_ROTATE_EN
    chk("t2_reg", sreg, 4'b1001);
`else
    chk("t2_reg", sreg, 4'b0000);
`endif
    chk("t2_latency", r_donec, 6);

    // Count 0: load only.
    run_cmd(1'b0, 4'b0110, 3'd0, 1'b1, 1'b0);
    chk("t3_load", r_load, 1);
    chk("t3_shifts", {r_left[3:0], r_right[3:0], r_nser[3:0]}, 12'h000);
    chk("t3_reg", sreg, 4'b0110);
    chk("t3_latency", r_donec, 2);

    // Count 7 clamps to 4 shifts.
    run_cmd(1'b1, 4'b1011, 3'd7, 1'b1, 1'b0);
    chk("t4_right", r_right, 4);
    chk("t4_ser", r_ser, 8'b0000_1101);
`ifdef SHIFT_CTRL_ROTATE_EN
    chk("t4_reg", sreg, 4'b1011);
`else
    chk("t4_reg", sreg, 4'b1111);
`endif
    chk("t4_latency", r_donec, 6);

    // Different command presented mid-shift must be ignored.
    run_cmd(1'b0, 4'b0101, 3'd3, 1'b0, 1'b1);
    chk("t5_left", r_left, 3);
    chk("t5_right", r_right, 0);
    chk("t5_load", r_load, 1);
    chk("t5_ser", r_ser, 8'b0000_0010);
`ifdef SHIFT_CTRL_ROTATE_EN
    chk("t5_reg", sreg, 4'b1010);
`else
    chk("t5_reg", sreg, 4'b1000);
`endif
    chk("t5_latency", r_donec, 5);
    @(negedge clk);
    chk("t5_no_restart", {busy, ParallelLoad}, 2'b00);

`ifdef SHIFT_CTRL_ROTATE_EN
    run_cmd(1'b0, 4'b1001, 3'd4, 1'b0, 1'b0);
    chk("rot_reg", sreg, 4'b1001);
    chk("rot_ser", r_ser, 8'b0000_1001);
    chk("rot_left", r_left, 4);
`endif

    // Reset in the second shift cycle aborts the command.
    cmdValid = 1'b1; cmdDir = 1'b0; cmdData = 4'b1001; cmdCount = 3'd4; cmdFill = 1'b0;
    @(posedge clk);
    #1 cmdValid = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_pre_shift", {ShiftLeft, busy}, 2'b11);
    rst = 1'b1;
    #1;
    chk("abort_strobes", {ParallelLoad, ShiftLeft, ShiftRight, ShiftInput, serialValid,
                          serialOut, busy, done, cmdReady}, 9'h0);
    dseen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done || ShiftLeft || ShiftRight) dseen++;
    end
    chk("abort_quiet", dseen, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_idle", {cmdReady, busy, done}, 3'b100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/shift_register_controller.md
# shift_register_controller

Command-driven sequencer for the team's 4-bit priority shift register (Reset > ParallelLoad > ShiftLeft > ShiftRight). It accepts a load-and-shift command over a valid/ready handshake and drives the register's control strobes cycle by cycle. It streams the bits leaving the register to a serial port and pulses `done` when finished. It sits between the command source (a bus slave or test sequencer) and the register datapath. It guarantees that the register never sees ShiftLeft and ShiftRight asserted together.

## Interface
- `WIDTH`, default 4: register width and width of `cmdData`/`Data`.
- `CNT_W`, default 3: width of the shift-count field.

- `clockPulse`, input, 1: the only clock; all state changes on its rising edge.
- `Reset`, input, 1: asynchronous, active-high reset.
- `cmdValid`, input, 1: command present.
- `cmdReady`, output, 1: controller can accept a command.
- `cmdDir`, input, 1: shift direction; 0 = left, 1 = right.
- `cmdData`, input, WIDTH: word to parallel-load.
- `cmdCount`, input, CNT_W: number of shifts. 0 = load only. Values above WIDTH are clamped to WIDTH.
- `cmdFill`, input, 1: serial fill bit shifted in.
- `ShiftOutput`, input, 1: bit leaving the register, combinational from register state.
- `ParallelLoad`, output, 1: load strobe to the register.
- `ShiftLeft`, output, 1: left-shift strobe.
- `ShiftRight`, output, 1: right-shift strobe.
- `ShiftInput`, output, 1: serial bit into the register.
- `Data`, output, WIDTH: parallel-load word.
- `serialOut`, output, 1: emitted bit.
- `serialValid`, output, 1: `serialOut` is valid this cycle.
- `busy`, output, 1: a command is in progress.
- `done`, output, 1: one-cycle completion pulse.

## Operation
- FSM states: IDLE, LOAD, SHIFT, DONE.
- **IDLE**
  - `cmdReady`=1 and all strobes are 0.
  - On `cmdValid & cmdReady` at an edge, capture `cmdDir`, `cmdData`, `cmdFill`, and the clamped count. Go to LOAD.
- **LOAD** (exactly 1 cycle)
  - `ParallelLoad`=1 and `Data`=captured word.
  - Next state is SHIFT if the count is nonzero, otherwise DONE.
- **SHIFT** (exactly `count` cycles)
  - Exactly one of `ShiftLeft`/`ShiftRight` is 1, selected by the captured direction.
  - `ShiftInput`=captured fill bit.
  - `serialValid`=1 and `serialOut`=`ShiftOutput`, i.e. the bit leaving at the coming edge.
  - The remaining-count register decrements each cycle. When it reaches 1, go to DONE.
- **DONE** (1 cycle)
  - `done`=1, then go to IDLE.
- `busy`=1 in LOAD, SHIFT and DONE.
- `Data` holds the captured word from LOAD until the next capture. Outside LOAD it has no effect on the register.
- `cmdValid` asserted while busy is ignored. It is not queued; the source must hold it until `cmdReady`.
- Clamp rule: `cmdCount` ≥ WIDTH gives WIDTH shifts.

## Timing
- Reset values while `Reset`=1 (immediate, asynchronous):
  - state = IDLE.
  - `cmdReady`=0.
  - `ParallelLoad`, `ShiftLeft`, `ShiftRight`, `ShiftInput`, `serialOut`, `serialValid`, `busy`, `done` = 0.
  - `Data`=0.
- The first `cmdReady`=1 is in the first cycle after `Reset` deasserts.
- All outputs are registered or decoded from registered state. There are no combinational paths from `cmd*` to outputs.
  - Exception: `serialOut` passes `ShiftOutput` straight through.
- Latency, for a command accepted at edge k with N shifts:
  - LOAD in cycle k..k+1.
  - Shift strobes in cycles k+1 .. k+N.
  - `done` in cycle k+N+1.
  - `cmdReady` again after edge k+N+2.
  - Total N+2 cycles.
- Reset mid-command aborts immediately: no `done` and no further strobes. The captured command is discarded.

## Configuration
- Macro `SHIFT_CTRL_ROTATE_EN`, defined: during SHIFT, `ShiftInput`=`ShiftOutput`, so the register rotates and `cmdFill` is ignored.
- Macro not defined: `ShiftInput`=captured `cmdFill`. Rotate logic is absent.

## Structure
- Shared package `shift_ctrl_pkg` holds:
  - the state enum (IDLE/LOAD/SHIFT/DONE);
  - direction constants `DIR_LEFT`=0 and `DIR_RIGHT`=1;
  - default WIDTH/CNT_W.
- Sub-module `shift_ctrl_counter`: loadable down-counter with a terminal-count flag, used for the remaining-shift count.
- The bench instantiates the controller plus the 4-bit priority shift register.

## Test plan
- Reset held 2 cycles → all outputs 0 and `cmdReady`=0. Deassert → `cmdReady`=1 next cycle.
- Command left, data 1001, count 1, fill 1:
  - LOAD strobe for 1 cycle, then 1 `ShiftLeft` cycle with `serialOut`=1.
  - Register = 0011, then `done` pulse; total 3 cycles.
- Command right, data 1001, count 4, fill 0:
  - 4 `ShiftRight` cycles; `serialOut` sequence 1,0,0,1.
  - Register = 0000; `ShiftLeft` stays 0 throughout.
- Count 0 with data 0110 → LOAD then DONE, no shift strobes, register = 0110. Count 7 → exactly 4 shifts.
- `cmdValid` asserted during SHIFT with a different command → ignored; the original sequence completes unchanged.
- `Reset` asserted in the 2nd shift cycle → all strobes drop immediately, no `done`, IDLE after release. With `SHIFT_CTRL_ROTATE_EN`: left, 1001, count 4 → register returns to 1001.
